// File: rtl/median_pkg.sv
// Shared constants for the median filter datapath and its output stage.
// Pixel and row geometry live here so every block agrees on packing.
package median_pkg;

   localparam int COL   = 256;
   localparam int ROWS  = 256;
   localparam int ROW   = ROWS;
   localparam int WIDTH = 8;
   localparam int PIX_W = 3 * WIDTH;

   // Counter width that stays legal for a range of a single value.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/median_row_serializer.sv
// Double-buffered row-to-pixel serializer at the median filter output.
// A hold row waits behind the shifting row; pixels leave MSB-first.
module median_row_serializer
   import median_pkg::*;
#(
   parameter int COL   = median_pkg::COL,
   parameter int ROWS  = median_pkg::ROWS,
   parameter int WIDTH = median_pkg::WIDTH
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     row_valid,
   output logic                     row_ready,
   input  logic [COL*WIDTH*3-1:0]   row_data,
   output logic                     px_valid,
   input  logic                     px_ready,
   output logic [3*WIDTH-1:0]       px_data,
   output logic                     px_last,
   output logic                     px_eof
);

   localparam int PW  = 3 * WIDTH;
   localparam int RW  = COL * PW;
   localparam int CW  = cnt_w(COL);
   localparam int RCW = cnt_w(ROWS);

   localparam logic [CW-1:0]  COL_LAST = CW'(COL - 1);
   localparam logic [RCW-1:0] ROW_LAST = RCW'(ROWS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [RW-1:0]   shift_q, shift_d;
   logic [RW-1:0]   hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RCW-1:0]  row_q, row_d;
   logic            last_q, last_d;
   logic            eof_q, eof_d;

   logic            row_hs;
   logic            px_hs;
   logic            last_hs;
   logic            load_en;

   assign row_ready = !hold_full_q && !RST;
   assign row_hs    = row_valid && row_ready;
   assign px_hs     = (state_q == SEND) && px_ready;
   assign last_hs   = px_hs && last_q;
   assign load_en   = (state_q == IDLE) || last_hs;

   assign px_valid  = (state_q == SEND);
   assign px_data   = shift_q[RW-1 -: PW];
   assign px_last   = last_q;
   assign px_eof    = eof_q;

   // Next-state: shift loads, pixel shifting, hold capture, counters.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      col_d       = col_q;
      row_d       = row_q;

      if (load_en) begin
         col_d = '0;
         if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = SEND;
         end else if (row_hs) begin
            shift_d = row_data;
            state_d = SEND;
         end else begin
            shift_d = '0;
            state_d = IDLE;
         end
      end else if (px_hs) begin
         shift_d = shift_q << PW;
         col_d   = CW'(col_q + 1'b1);
      end

      // A row handshake implies an empty hold, so only a bypass
      // load can consume it; otherwise it parks in the hold.
      if (row_hs && !load_en) begin
         hold_d      = row_data;
         hold_full_d = 1'b1;
      end

      if (last_hs) begin
         row_d = eof_q ? '0 : RCW'(row_q + 1'b1);
      end

      last_d = (state_d == SEND) && (col_d == COL_LAST);
      eof_d  = last_d && (row_d == ROW_LAST);
   end

   // State register with synchronous reset dropping both buffers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         last_q      <= 1'b0;
         eof_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         col_q       <= col_d;
         row_q       <= row_d;
         last_q      <= last_d;
         eof_q       <= eof_d;
      end
   end

endmodule

// File: tb/tb_median_row_serializer.sv
// Directed bench for median_row_serializer with a 4-pixel, 2-row frame.
// Each task drives one scenario and checks outputs 1ns after the edge.
module tb_median_row_serializer;

   localparam int COL   = 4;
   localparam int ROWS  = 2;
   localparam int WIDTH = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          row_valid;
   logic          row_ready;
   logic [95:0]   row_data;
   logic          px_valid;
   logic          px_ready;
   logic [23:0]   px_data;
   logic          px_last;
   logic          px_eof;

   int checks   = 0;
   int failures = 0;

   localparam logic [95:0] ROW_A = 96'h112233_445566_778899_AABBCC;
   localparam logic [95:0] ROW_B = 96'h010203_040506_070809_0A0B0C;
   localparam logic [95:0] ROW_C = 96'hC0C1C2_D0D1D2_E0E1E2_F0F1F2;

   median_row_serializer #(
      .COL   (COL),
      .ROWS  (ROWS),
      .WIDTH (WIDTH)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_data  (row_data),
      .px_valid  (px_valid),
      .px_ready  (px_ready),
      .px_data   (px_data),
      .px_last   (px_last),
      .px_eof    (px_eof)
   );

   always #5 CLK = ~CLK;

   function automatic logic [23:0] pix(input logic [95:0] r, input int i);
      return r[95 - 24*i -: 24];
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RST       = 1'b1;
      row_valid = 1'b0;
      px_ready  = 1'b0;
      row_data  = '0;
      step();
      step();
      RST = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      RST       = 1'b1;
      row_valid = 1'b1;
      row_data  = ROW_A;
      px_ready  = 1'b1;
      step();
      step();
      checks++;
      if ({px_valid, px_last, px_eof} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000",
                  {px_valid, px_last, px_eof});
      end
      checks++;
      if (px_data !== 24'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=000000", px_data);
      end
      checks++;
      if (row_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_row_ready got=%b exp=0", row_ready);
      end
      row_valid = 1'b0;
      RST = 1'b0;
      #1;
      checks++;
      if (row_ready !== 1'b1) begin
         failures++;
         $display("FAIL release_row_ready got=%b exp=1", row_ready);
      end
   endtask

   task automatic test_single_row();
      apply_reset();
      px_ready  = 1'b1;
      row_valid = 1'b1;
      row_data  = ROW_A;
      step();
      row_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if ({px_valid, px_last, px_eof, px_data} !==
             {1'b1, (c == 3), 1'b0, pix(ROW_A, c)}) begin
            failures++;
            $display("FAIL single_px%0d got=%b%b%b_%h exp=1%b0_%h",
                     c, px_valid, px_last, px_eof, px_data,
                     (c == 3), pix(ROW_A, c));
         end
         step();
      end
      checks++;
      if (px_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_drain got=%b exp=0", px_valid);
      end
   endtask

   task automatic test_stall();
      int idx;
      apply_reset();
      px_ready  = 1'b0;
      row_valid = 1'b1;
      row_data  = ROW_A;
      step();
      row_valid = 1'b0;
      idx = 0;
      for (int c = 0; c < 20 && idx < 4; c++) begin
         px_ready = (c % 3 == 0);
         checks++;
         if ({px_valid, px_last, px_eof, px_data} !==
             {1'b1, (idx == 3), 1'b0, pix(ROW_A, idx)}) begin
            failures++;
            $display("FAIL stall_c%0d got=%b%b%b_%h exp=1%b0_%h",
                     c, px_valid, px_last, px_eof, px_data,
                     (idx == 3), pix(ROW_A, idx));
         end
         if (px_ready) idx++;
         step();
      end
      px_ready = 1'b0;
      checks++;
      if (idx !== 4 || px_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_count got=%0d/%b exp=4/0", idx, px_valid);
      end
   endtask

   task automatic test_double_buffer();
      logic [95:0] r;
      logic        exp_rdy;
      apply_reset();
      px_ready  = 1'b0;
      row_valid = 1'b1;
      row_data  = ROW_A;
      checks++;
      if (row_ready !== 1'b1) begin
         failures++;
         $display("FAIL dbuf_accept_a got=%b exp=1", row_ready);
      end
      step();
      row_data = ROW_B;
      checks++;
      if (row_ready !== 1'b1) begin
         failures++;
         $display("FAIL dbuf_accept_b got=%b exp=1", row_ready);
      end
      step();
      row_data = ROW_C;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({row_ready, px_valid, px_data} !==
             {1'b0, 1'b1, pix(ROW_A, 0)}) begin
            failures++;
            $display("FAIL dbuf_full%0d got=%b%b_%h exp=01_%h",
                     c, row_ready, px_valid, px_data, pix(ROW_A, 0));
         end
         step();
      end
      px_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         row_valid = (c <= 4);
         r = (c < 4) ? ROW_A : (c < 8) ? ROW_B : ROW_C;
         exp_rdy = (c == 4) || (c >= 8);
         checks++;
         if (row_ready !== exp_rdy) begin
            failures++;
            $display("FAIL dbuf_rdy_c%0d got=%b exp=%b",
                     c, row_ready, exp_rdy);
         end
         checks++;
         if ({px_valid, px_last, px_eof, px_data} !==
             {1'b1, (c % 4 == 3), (c == 7), pix(r, c % 4)}) begin
            failures++;
            $display("FAIL dbuf_px_c%0d got=%b%b%b_%h exp=1%b%b_%h",
                     c, px_valid, px_last, px_eof, px_data,
                     (c % 4 == 3), (c == 7), pix(r, c % 4));
         end
         step();
      end
      row_valid = 1'b0;
      checks++;
      if (px_valid !== 1'b0) begin
         failures++;
         $display("FAIL dbuf_drain got=%b exp=0", px_valid);
      end
   endtask

   task automatic test_bypass_eof();
      logic [95:0] r;
      apply_reset();
      px_ready  = 1'b1;
      row_valid = 1'b1;
      row_data  = ROW_A;
      step();
      row_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         row_valid = (c == 3) || (c == 7);
         row_data  = (c < 4) ? ROW_B : ROW_C;
         r = (c < 4) ? ROW_A : (c < 8) ? ROW_B : ROW_C;
         if (c == 3) begin
            checks++;
            if (row_ready !== 1'b1) begin
               failures++;
               $display("FAIL bypass_rdy got=%b exp=1", row_ready);
            end
         end
         checks++;
         if ({px_valid, px_last, px_eof, px_data} !==
             {1'b1, (c % 4 == 3), (c == 7), pix(r, c % 4)}) begin
            failures++;
            $display("FAIL bypass_px_c%0d got=%b%b%b_%h exp=1%b%b_%h",
                     c, px_valid, px_last, px_eof, px_data,
                     (c % 4 == 3), (c == 7), pix(r, c % 4));
         end
         step();
      end
      row_valid = 1'b0;
      checks++;
      if (px_valid !== 1'b0) begin
         failures++;
         $display("FAIL bypass_drain got=%b exp=0", px_valid);
      end
   endtask

   task automatic test_reset_mid_row();
      apply_reset();
      px_ready  = 1'b1;
      row_valid = 1'b1;
      row_data  = ROW_A;
      step();
      row_valid = 1'b0;
      for (int c = 0; c < 4; c++) step();
      row_valid = 1'b1;
      row_data  = ROW_C;
      step();
      row_valid = 1'b0;
      step();
      step();
      checks++;
      if ({px_valid, px_data} !== {1'b1, pix(ROW_C, 2)}) begin
         failures++;
         $display("FAIL mid_pre got=%b_%h exp=1_%h",
                  px_valid, px_data, pix(ROW_C, 2));
      end
      RST = 1'b1;
      #1;
      checks++;
      if (row_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst_rdy got=%b exp=0", row_ready);
      end
      step();
      checks++;
      if ({px_valid, row_ready, px_data} !== {2'b00, 24'h0}) begin
         failures++;
         $display("FAIL mid_rst_out got=%b%b_%h exp=00_000000",
                  px_valid, row_ready, px_data);
      end
      RST = 1'b0;
      #1;
      checks++;
      if ({px_valid, row_ready} !== 2'b01) begin
         failures++;
         $display("FAIL mid_release got=%b%b exp=01",
                  px_valid, row_ready);
      end
      row_valid = 1'b1;
      row_data  = ROW_B;
      step();
      row_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if ({px_valid, px_last, px_eof, px_data} !==
             {1'b1, (c == 3), 1'b0, pix(ROW_B, c)}) begin
            failures++;
            $display("FAIL mid_px%0d got=%b%b%b_%h exp=1%b0_%h",
                     c, px_valid, px_last, px_eof, px_data,
                     (c == 3), pix(ROW_B, c));
         end
         step();
      end
   endtask

   initial begin
      RST       = 1'b1;
      row_valid = 1'b0;
      row_data  = '0;
      px_ready  = 1'b0;
      test_reset();
      test_single_row();
      test_stall();
      test_double_buffer();
      test_bypass_eof();
      test_reset_mid_row();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
